// File: rtl/wb_arbiter.sv
// Two-requester register-file writeback arbiter with a destination scoreboard.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise requester B always wins.
module wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [3:0]  a_reg,
    input  logic [15:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [3:0]  b_reg,
    input  logic [15:0] b_data,
    output logic        b_ready,
    input  logic        rsv_valid,
    input  logic [3:0]  rsv_reg,
    input  logic [3:0]  chk_reg1,
    input  logic [3:0]  chk_reg2,
    output logic        chk_busy1,
    output logic        chk_busy2,
    output logic        WriteReg,
    output logic [3:0]  DstReg,
    output logic [15:0] DstData,
    output logic [15:0] busy_vec
);

    logic        writeReg_q, writeReg_d;
    logic [3:0]  dstReg_q, dstReg_d;
    logic [15:0] dstData_q, dstData_d;
    logic [15:0] busy_q, busy_d;
    logic        aWins;
    logic        accept;
    logic [3:0]  accReg;
    logic [15:0] accData;

`ifdef WB_ARB_ROUND_ROBIN_EN
    // Set when B took the most recent grant, so A is owed the next contention.
    logic lastGrantB_q, lastGrantB_d;
    assign aWins = lastGrantB_q;
`else
    assign aWins = 1'b0;
`endif

    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst) begin
            a_ready = a_valid && (!b_valid || aWins);
            b_ready = b_valid && !(a_valid && aWins);
        end
    end

    assign accept  = a_ready || b_ready;
    assign accReg  = a_ready ? a_reg  : b_reg;
    assign accData = a_ready ? a_data : b_data;

    always_comb begin
        writeReg_d = accept && (accReg != 4'd0);
        dstReg_d   = dstReg_q;
        dstData_d  = dstData_q;
        busy_d     = busy_q;
        if (accept) begin
            dstReg_d  = accReg;
            dstData_d = accData;
            busy_d[accReg] = 1'b0;
        end
        // Applied after the clear so a same-register reservation wins.
        if (rsv_valid) begin
            busy_d[rsv_reg] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

`ifdef WB_ARB_ROUND_ROBIN_EN
    always_comb begin
        lastGrantB_d = lastGrantB_q;
        if (accept) begin
            lastGrantB_d = b_ready;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastGrantB_q <= 1'b1;
        end else begin
            lastGrantB_q <= lastGrantB_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            writeReg_q <= 1'b0;
            dstReg_q   <= 4'd0;
            dstData_q  <= 16'd0;
            busy_q     <= 16'd0;
        end else begin
            writeReg_q <= writeReg_d;
            dstReg_q   <= dstReg_d;
            dstData_q  <= dstData_d;
            busy_q     <= busy_d;
        end
    end

    assign WriteReg  = writeReg_q;
    assign DstReg    = dstReg_q;
    assign DstData   = dstData_q;
    assign busy_vec  = busy_q;
    assign chk_busy1 = (chk_reg1 != 4'd0) && busy_q[chk_reg1];
    assign chk_busy2 = (chk_reg2 != 4'd0) && busy_q[chk_reg2];

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized run
// compared against a behavioural model of the writeback/scoreboard rules.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0;
    logic [3:0]  a_reg = 4'd0;
    logic [15:0] a_data = 16'd0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [3:0]  b_reg = 4'd0;
    logic [15:0] b_data = 16'd0;
    logic        b_ready;
    logic        rsv_valid = 1'b0;
    logic [3:0]  rsv_reg = 4'd0;
    logic [3:0]  chk_reg1 = 4'd0;
    logic [3:0]  chk_reg2 = 4'd0;
    logic        chk_busy1;
    logic        chk_busy2;
    logic        WriteReg;
    logic [3:0]  DstReg;
    logic [15:0] DstData;
    logic [15:0] busy_vec;

    int errors = 0;
    int checks = 0;

    // Behavioural model: set of busy registers, the pending register-file write,
    // and who won the most recent grant (0 = A, 1 = B).
    bit          mBusy [16];
    logic        mWrite;
    logic [3:0]  mDstReg;
    logic [15:0] mDstData;
    int          lastWinner;

    // Values seen mid-cycle in the latest step, for directed checks.
    logic obsA, obsB, obsBusy1;

    wb_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
        .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
        .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
        .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
        .busy_vec(busy_vec)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] modelBusyVec();
        logic [15:0] v;
        v = 16'd0;
        for (int r = 1; r < 16; r++) begin
            v[r] = mBusy[r];
        end
        return v;
    endfunction

    function automatic logic modelAWinsTie();
`ifdef WB_ARB_ROUND_ROBIN_EN
        return lastWinner == 1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic modelReset();
        for (int r = 0; r < 16; r++) begin
            mBusy[r] = 1'b0;
        end
        mWrite     = 1'b0;
        mDstReg    = 4'd0;
        mDstData   = 16'd0;
        lastWinner = 1;
    endtask

    // Drive one cycle of inputs, check the combinational outputs mid-cycle,
    // then advance the model across the edge and check the registered outputs.
    task automatic applyStimulus(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                                 input logic bv, input logic [3:0] br, input logic [15:0] bd,
                                 input logic rv, input logic [3:0] rr,
                                 input logic [3:0] c1, input logic [3:0] c2);
        logic        expA, expB, acc;
        logic [3:0]  accReg;
        logic [15:0] accData;
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        rsv_valid = rv; rsv_reg = rr;
        chk_reg1 = c1; chk_reg2 = c2;
        @(negedge clk);
        expA = av && (!bv || modelAWinsTie());
        expB = bv && !expA;
        obsA = a_ready;
        obsB = b_ready;
        obsBusy1 = chk_busy1;
        checkOutput("a_ready", 16'(a_ready), 16'(expA));
        checkOutput("b_ready", 16'(b_ready), 16'(expB));
        checkOutput("chk_busy1", 16'(chk_busy1), 16'(mBusy[c1] && c1 != 4'd0));
        checkOutput("chk_busy2", 16'(chk_busy2), 16'(mBusy[c2] && c2 != 4'd0));
        @(posedge clk);
        acc     = expA || expB;
        accReg  = expA ? ar : br;
        accData = expA ? ad : bd;
        if (acc) begin
            mWrite     = (accReg != 4'd0);
            mDstReg    = accReg;
            mDstData   = accData;
            lastWinner = expB ? 1 : 0;
        end else begin
            mWrite = 1'b0;
        end
        for (int r = 1; r < 16; r++) begin
            if (rv && rr == 4'(r)) mBusy[r] = 1'b1;
            else if (acc && accReg == 4'(r)) mBusy[r] = 1'b0;
        end
        #1;
        checkOutput("WriteReg", 16'(WriteReg), 16'(mWrite));
        checkOutput("DstReg", 16'(DstReg), 16'(mDstReg));
        checkOutput("DstData", DstData, mDstData);
        checkOutput("busy_vec", busy_vec, modelBusyVec());
    endtask

    task automatic idleStep();
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 4'd0, 4'd0);
    endtask

    // Hold reset across an edge with requests offered, which must be refused.
    task automatic doReset();
        rst = 1'b1;
        a_valid = 1'b1; a_reg = 4'd3; b_valid = 1'b1; b_reg = 4'd4;
        rsv_valid = 1'b0;
        #2;
        checkOutput("rst_a_ready", 16'(a_ready), 16'd0);
        checkOutput("rst_b_ready", 16'(b_ready), 16'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_WriteReg", 16'(WriteReg), 16'd0);
        checkOutput("rst_DstReg", 16'(DstReg), 16'd0);
        checkOutput("rst_DstData", DstData, 16'd0);
        checkOutput("rst_busy_vec", busy_vec, 16'd0);
        a_valid = 1'b0; b_valid = 1'b0;
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        logic        pendA, pendB;
        logic        av, bv, rv;
        logic [3:0]  ar, br, rr;
        logic [15:0] ad, bd;
        logic        g [3];
        logic        gA [3];

        modelReset();
        @(posedge clk);
        #1;
        doReset();

        // Single write from A: one-cycle latency, one-cycle pulse.
        applyStimulus(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 4'd0, 4'd0);
        checkOutput("single_a_ready", 16'(obsA), 16'd1);
        checkOutput("single_WriteReg", 16'(WriteReg), 16'd1);
        checkOutput("single_DstReg", 16'(DstReg), 16'd3);
        checkOutput("single_DstData", DstData, 16'h1234);
        idleStep();
        checkOutput("single_WriteReg_drop", 16'(WriteReg), 16'd0);
        checkOutput("single_DstData_hold", DstData, 16'h1234);

        // Three cycles of contention from a fresh reset.
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'd1, 16'hAAAA, 1'b1, 4'd2, 16'hBBBB, 1'b0, 4'd0, 4'd0, 4'd0);
            g[i]  = obsB;
            gA[i] = obsA;
        end
`ifdef WB_ARB_ROUND_ROBIN_EN
        checkOutput("rr_grant0_is_b", 16'(g[0]), 16'd0);
        checkOutput("rr_grant1_is_b", 16'(g[1]), 16'd1);
        checkOutput("rr_grant2_is_b", 16'(g[2]), 16'd0);
`else
        for (int i = 0; i < 3; i++) begin
            checkOutput("fixed_grant_is_b", 16'(g[i]), 16'd1);
            checkOutput("fixed_a_ready", 16'(gA[i]), 16'd0);
        end
`endif

        // Reservation, hazard check, then clear by B's writeback.
        doReset();
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd5, 4'd0, 4'd0);
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 4'd5, 4'd0);
        checkOutput("rsv_chk_busy1", 16'(obsBusy1), 16'd1);
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 4'd5, 16'h5555, 1'b0, 4'd0, 4'd0, 4'd0);
        checkOutput("clear_busy5", 16'(busy_vec[5]), 16'd0);

        // Reserve and clear of the same register on one edge: set wins.
        applyStimulus(1'b1, 4'd7, 16'h7777, 1'b0, 4'd0, 16'd0, 1'b1, 4'd7, 4'd0, 4'd0);
        checkOutput("set_wins_busy7", 16'(busy_vec[7]), 16'd1);

        // Register 0: accepted, never written, never reserved.
        doReset();
        applyStimulus(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'd0, 1'b1, 4'd0, 4'd0, 4'd0);
        checkOutput("r0_a_ready", 16'(obsA), 16'd1);
        checkOutput("r0_WriteReg", 16'(WriteReg), 16'd0);
        checkOutput("r0_busy_vec", busy_vec, 16'd0);

        // Asynchronous reset while a write is in the output stage.
        doReset();
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd4, 4'd0, 4'd0);
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd5, 4'd0, 4'd0);
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd6, 4'd0, 4'd0);
        applyStimulus(1'b1, 4'd9, 16'hC0DE, 1'b0, 4'd0, 16'd0, 1'b1, 4'd7, 4'd0, 4'd0);
        checkOutput("pre_async_busy", busy_vec, 16'h00F0);
        checkOutput("pre_async_WriteReg", 16'(WriteReg), 16'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_WriteReg", 16'(WriteReg), 16'd0);
        checkOutput("async_busy_vec", busy_vec, 16'd0);
        checkOutput("async_DstData", DstData, 16'd0);
        doReset();

        // Randomized traffic; a requester that lost holds its request stable.
        pendA = 1'b0;
        pendB = 1'b0;
        ar = 4'd0; ad = 16'd0; br = 4'd0; bd = 16'd0;
        for (int i = 0; i < 400; i++) begin
            if (pendA) begin
                av = 1'b1;
            end else begin
                av = 1'($urandom_range(0, 1));
                ar = 4'($urandom_range(0, 15));
                ad = 16'($urandom);
            end
            if (pendB) begin
                bv = 1'b1;
            end else begin
                bv = 1'($urandom_range(0, 1));
                br = 4'($urandom_range(0, 15));
                bd = 16'($urandom);
            end
            rv = 1'($urandom_range(0, 1));
            rr = 4'($urandom_range(0, 15));
            applyStimulus(av, ar, ad, bv, br, bd, rv, rr,
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            pendA = av && !obsA;
            pendB = bv && !obsB;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
